pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Ports SHALL be, clock and reset first:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- de_valid  in  1  decode stage holds a valid instruction
- de_rs1, de_rs2  in  5 each  decode source register addresses
- ex_valid, ex_is_load, ex_wr  in  1 each  EX stage valid / is a load / writes rd
- ex_rd  in  5  EX destination register
- mem_valid, mem_wr  in  1 each  MEM stage valid / writes rd
- mem_rd  in  5  MEM destination register
- branch_taken  in  1  EX resolved a taken branch or jump
- trap_req  in  1  EX raises an exception (illegal, ecall, ebreak) or mret
- dmem_req  in  1  MEM stage issues a data-memory access
- dmem_ack  in  1  data memory completes the access this cycle
- fe_stall, de_stall, ex_stall  out  1 each  hold the stage registers
- fe_flush, de_flush, ex_flush  out  1 each  invalidate the stage output
- trap_commit  out  1  one-cycle pulse; PC redirects to the trap/mret target
- state  out  2  FSM state: RUN=0, MEMWAIT=1, TRAP=2
- stall_cnt  out  32  saturating count of stalled cycles
REQ-002 Parameters: none; all widths are fixed.

Function
REQ-003 FSM states SHALL be RUN, MEMWAIT and TRAP; encoding 3 is illegal and SHALL return to RUN on the next clock.
REQ-004 RUN transitions SHALL be evaluated in this priority order:
- trap_req && ex_valid -> TRAP
- else dmem_req && !dmem_ack -> MEMWAIT
- else stay in RUN.
REQ-005 MEMWAIT SHALL stay in MEMWAIT until dmem_ack=1, then go to RUN.
REQ-006 While in MEMWAIT, trap_req SHALL be ignored; EX is held, so the trap is taken after the return to RUN.
REQ-007 TRAP SHALL last exactly 1 cycle, then go to RUN.
REQ-008 In TRAP, fe/de/ex_flush=1, all stalls=0 and trap_commit=1; trap_commit SHALL be 0 in every other cycle.
REQ-009 Memory-wait stall:
- Condition: MEMWAIT, or (RUN && dmem_req && !dmem_ack && !trap_req).
- Response: all three stalls=1, all flushes=0.
REQ-010 Branch flush: in RUN with branch_taken=1 and no trap and no memory wait, fe_flush=de_flush=1, ex_flush=0, no stalls.
REQ-011 Branch flush SHALL override a load-use hazard in the same cycle (the consumer is flushed).
REQ-012 Load-use hazard (hz):
- Condition: de_valid && ex_valid && ex_is_load && ex_wr && ex_rd!=0 && (ex_rd==de_rs1 || ex_rd==de_rs2).
- Response: fe_stall=de_stall=1, ex_flush=1 (bubble), ex_stall=0.
REQ-013 Hazard detection and flush/stall outputs SHALL be combinational (same-cycle) from state and inputs; state and stall_cnt are registered.
REQ-014 A register address of 0 SHALL never create a hazard.
REQ-015 stall_cnt SHALL increment by 1 on each clock where any stall output is 1, and SHALL saturate at 0xFFFF_FFFF.
REQ-016 With no event active, all stall and flush outputs SHALL be 0.

Reset
REQ-017 While rst=1:
- state=RUN, stall_cnt=0.
- All stall, flush and trap_commit outputs forced to 0, regardless of inputs.
REQ-018 Reset asserted in MEMWAIT or TRAP SHALL abort the operation immediately; the first cycle after deassertion is RUN.

Configuration
REQ-019 Macro FORWARDING_EN:
- Defined: hazard per REQ-012 (load-use only).
- Undefined: a hazard also exists when (ex_valid && ex_wr && ex_rd!=0) or (mem_valid && mem_wr && mem_rd!=0) matches de_rs1 or de_rs2, for any instruction type.
- Same stall/bubble response in both cases.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- Load-use: ex_is_load=1, ex_rd=5, de_rs2=5 for 1 cycle -> fe/de_stall=1, ex_flush=1 that cycle; stall_cnt=1.
- Memory wait: dmem_req=1, dmem_ack low 3 cycles then high -> all stalls=1 for 4 cycles; state sequence 0,1,1,1,0; stall_cnt=4.
- Trap: trap_req=1 together with branch_taken=1 -> next cycle state=2, trap_commit=1, all flushes=1; following cycle state=0.
- Branch vs load-use: branch_taken=1 with hazard present -> fe/de_flush=1, no stalls.
- Reset mid-MEMWAIT: rst=1 -> state=0 and outputs 0 immediately; stall_cnt=0.
- Saturation and x0: force stall_cnt=0xFFFF_FFFE, 3 stall cycles -> holds 0xFFFF_FFFF; ex_rd=0 with a load -> no stall.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard / stall / flush controller for a 5-stage pipeline.
// Tracks memory waits and trap redirects with a small FSM and counts stalled cycles.
// Optional feature: define FORWARDING_EN when the datapath has full forwarding.
// In that build only load-use creates a hazard. Without it, any in-flight write
// in EX or MEM to a decode source register creates a hazard.
//
// state   | meaning
// RUN     | normal flow; hazards, branch flushes and memory-wait entry evaluated
// MEMWAIT | data memory busy; whole front of the pipe held until dmem_ack
// TRAP    | single redirect cycle; all stages flushed, trap_commit pulsed
module pipeline_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        de_valid,
    input  logic [4:0]  de_rs1,
    input  logic [4:0]  de_rs2,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_wr,
    input  logic [4:0]  ex_rd,
    input  logic        mem_valid,
    input  logic        mem_wr,
    input  logic [4:0]  mem_rd,
    input  logic        branch_taken,
    input  logic        trap_req,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        fe_stall,
    output logic        de_stall,
    output logic        ex_stall,
    output logic        fe_flush,
    output logic        de_flush,
    output logic        ex_flush,
    output logic        trap_commit,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        TRAP    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic load_use, hz, trap_ev, mem_wait_run;
    logic fe_stall_c, de_stall_c, ex_stall_c;
    logic fe_flush_c, de_flush_c, ex_flush_c, trap_commit_c;

    // Hazard detection; register 0 is never a real dependency.
    always_comb begin
        load_use = de_valid && ex_valid && ex_is_load && ex_wr && (ex_rd != 5'd0) &&
                   ((ex_rd == de_rs1) || (ex_rd == de_rs2));
`ifdef FORWARDING_EN
        hz = load_use;
`else
        hz = load_use ||
             (de_valid && ex_valid && ex_wr && (ex_rd != 5'd0) &&
              ((ex_rd == de_rs1) || (ex_rd == de_rs2))) ||
             (de_valid && mem_valid && mem_wr && (mem_rd != 5'd0) &&
              ((mem_rd == de_rs1) || (mem_rd == de_rs2)));
`endif
    end

    // Next-state and raw stall/flush decode; trap beats memory wait beats branch beats hazard.
    always_comb begin
        state_d       = RUN;
        fe_stall_c    = 1'b0;
        de_stall_c    = 1'b0;
        ex_stall_c    = 1'b0;
        fe_flush_c    = 1'b0;
        de_flush_c    = 1'b0;
        ex_flush_c    = 1'b0;
        trap_commit_c = 1'b0;
        trap_ev       = trap_req && ex_valid;
        mem_wait_run  = dmem_req && !dmem_ack && !trap_req;
        case (state_q)
            RUN: begin
                if (trap_ev) begin
                    state_d = TRAP;
                end else if (dmem_req && !dmem_ack) begin
                    state_d = MEMWAIT;
                end else begin
                    state_d = RUN;
                end
                if (mem_wait_run) begin
                    fe_stall_c = 1'b1;
                    de_stall_c = 1'b1;
                    ex_stall_c = 1'b1;
                end else if (!trap_ev && branch_taken) begin
                    // The flushed consumer makes any load-use hazard moot.
                    fe_flush_c = 1'b1;
                    de_flush_c = 1'b1;
                end else if (!trap_ev && hz) begin
                    fe_stall_c = 1'b1;
                    de_stall_c = 1'b1;
                    ex_flush_c = 1'b1;
                end
            end
            MEMWAIT: begin
                // EX is frozen here, so a pending trap is picked up back in RUN.
                fe_stall_c = 1'b1;
                de_stall_c = 1'b1;
                ex_stall_c = 1'b1;
                state_d    = dmem_ack ? RUN : MEMWAIT;
            end
            TRAP: begin
                fe_flush_c    = 1'b1;
                de_flush_c    = 1'b1;
                ex_flush_c    = 1'b1;
                trap_commit_c = 1'b1;
                state_d       = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Reset silences every control output combinationally.
    always_comb begin
        fe_stall    = fe_stall_c    && !rst;
        de_stall    = de_stall_c    && !rst;
        ex_stall    = ex_stall_c    && !rst;
        fe_flush    = fe_flush_c    && !rst;
        de_flush    = de_flush_c    && !rst;
        ex_flush    = ex_flush_c    && !rst;
        trap_commit = trap_commit_c && !rst;
        state       = state_q;
        stall_cnt   = stall_cnt_q;
    end

    // Saturating stalled-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((fe_stall || de_stall || ex_stall) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
